// File: rtl/mem_stall_ctrl.sv
// M-stage memory sequencer: req/ack handshake to a variable-latency data memory,
// whole-pipeline freeze while an access is outstanding, and load-use bubble insertion.
// All state updates on the falling clock edge, in step with the pipeline registers.
module mem_stall_ctrl #(
  parameter int unsigned data_size = 32,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemRead,
  input  logic                 M_MemWrite,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  input  logic                 EX_MemtoReg,
  input  logic                 EX_RegWrite,
  input  logic [4:0]           EX_WR_out,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 dm_ack,
  input  logic [data_size-1:0] dm_rdata,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [data_size-1:0] dm_addr,
  output logic [data_size-1:0] dm_wdata,
  output logic [data_size-1:0] M_load_data,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exm_en,
  output logic                 mwb_en,
  output logic                 idex_flush,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     perf_mem_stall,
  output logic [CNT_W-1:0]     perf_lu_stall
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [data_size-1:0] addr_q, addr_d;
  logic [data_size-1:0] wdata_q, wdata_d;
  logic [data_size-1:0] load_q, load_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]     pmem_q, pmem_d;
  logic [CNT_W-1:0]     plu_q, plu_d;

  logic mem_op, lu, stall_mem;

  // Hazard detection and pipeline enables; reset forces every enable high.
  always_comb begin
    mem_op    = M_MemRead | M_MemWrite;
    lu        = !rst && EX_MemtoReg && EX_RegWrite && (EX_WR_out != 5'd0) &&
                ((EX_WR_out == ID_Rs) || (EX_WR_out == ID_Rt));
    stall_mem = !rst && (((state_q == StIdle) && mem_op) || (state_q == StReq));
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exm_en     = 1'b1;
    mwb_en     = 1'b1;
    idex_flush = 1'b0;
    if (stall_mem) begin
      // Freeze dominates; a pending load-use is picked up once the access releases.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exm_en  = 1'b0;
      mwb_en  = 1'b0;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next-state for the handshake FSM, latched request fields and perf counters.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          addr_d  = M_ALU_result;
          wdata_d = M_Rt_data;
          we_d    = M_MemWrite;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (dm_ack) begin
          if (!we_q) load_d = dm_rdata;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_q == TLast) begin
          err_d   = 1'b1;
          load_d  = '0;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      // Pipeline advances this edge; always return to idle so nothing is re-issued.
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    pmem_d = (stall_mem && (pmem_q != '1)) ? pmem_q + CNT_W'(1) : pmem_q;
    plu_d  = (lu && !stall_mem && (plu_q != '1)) ? plu_q + CNT_W'(1) : plu_q;
  end

  // State register on the falling edge with asynchronous active-high reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pmem_q  <= '0;
      plu_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pmem_q  <= pmem_d;
      plu_q   <= plu_d;
    end
  end

  assign dm_req         = req_q;
  assign dm_we          = we_q;
  assign dm_addr        = addr_q;
  assign dm_wdata       = wdata_q;
  assign M_load_data    = load_q;
  assign bus_err        = err_q;
  assign perf_mem_stall = pmem_q;
  assign perf_lu_stall  = plu_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: enable-equation table plus multi-cycle sequences.
module tb_mem_stall_ctrl;

  logic        clk, rst;
  logic        M_MemRead, M_MemWrite;
  logic [31:0] M_ALU_result, M_Rt_data;
  logic        EX_MemtoReg, EX_RegWrite;
  logic [4:0]  EX_WR_out, ID_Rs, ID_Rt;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, M_load_data;
  logic        pc_en, ifid_en, idex_en, exm_en, mwb_en, idex_flush, bus_err;
  logic [31:0] perf_mem_stall, perf_lu_stall;

  int n_checks = 0;
  int n_errors = 0;

  mem_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
    .M_ALU_result(M_ALU_result), .M_Rt_data(M_Rt_data),
    .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_WR_out(EX_WR_out),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .M_load_data(M_load_data),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exm_en(exm_en), .mwb_en(mwb_en),
    .idex_flush(idex_flush), .bus_err(bus_err),
    .perf_mem_stall(perf_mem_stall), .perf_lu_stall(perf_lu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd, wr, mtr, rw;
    logic [4:0] wr_out, rs, rt;
    logic [5:0] exp;  // {pc, ifid, idex, exm, mwb, flush}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ens();
    return {26'd0, pc_en, ifid_en, idex_en, exm_en, mwb_en, idex_flush};
  endfunction

  // Cross a falling (active) edge and land mid high phase.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    M_MemRead = 0; M_MemWrite = 0; EX_MemtoReg = 0; EX_RegWrite = 0;
    EX_WR_out = 0; ID_Rs = 0; ID_Rt = 0; dm_ack = 0;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 6'b111110};
    vecs[1] = '{0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 6'b001111};
    vecs[2] = '{0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 6'b001111};
    vecs[3] = '{0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 6'b111110};
    vecs[4] = '{0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 6'b111110};
    vecs[5] = '{0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 6'b111110};
    vecs[6] = '{0, 0, 1, 1, 5'd5, 5'd6, 5'd4, 6'b111110};
    vecs[7] = '{1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 6'b000000};
    vecs[8] = '{0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 6'b000000};
    vecs[9] = '{1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 6'b000000};

    clr_in();
    M_ALU_result = 0; M_Rt_data = 0; dm_rdata = 0;
    rst = 1;
    // Reset with a pending mem op and load-use: enables must still all be 1.
    M_MemRead = 1; EX_MemtoReg = 1; EX_RegWrite = 1; EX_WR_out = 5'd3; ID_Rs = 5'd3;
    #2;
    chk("rst_enables", ens(), 32'b111110);
    chk("rst_dm_req", {31'd0, dm_req}, 0);
    chk("rst_dm_we", {31'd0, dm_we}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_load", M_load_data, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);
    chk("rst_perf_mem", perf_mem_stall, 0);
    chk("rst_perf_lu", perf_lu_stall, 0);
    clr_in();
    tick();
    rst = 0;
    tick();

    // Enable equations from idle, no edge taken with these inputs.
    for (int i = 0; i < 10; i++) begin
      M_MemRead = vecs[i].rd; M_MemWrite = vecs[i].wr;
      EX_MemtoReg = vecs[i].mtr; EX_RegWrite = vecs[i].rw;
      EX_WR_out = vecs[i].wr_out; ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt;
      #1;
      chk($sformatf("vec%0d_enables", i), ens(), {26'd0, vecs[i].exp});
      clr_in();
      tick();
    end
    chk("vec_perf_lu_zero", perf_lu_stall, 0);
    chk("vec_perf_mem_zero", perf_mem_stall, 0);

    // 1. Load acked in 3rd REQ cycle.
    M_MemRead = 1; M_ALU_result = 32'h100;
    #1 chk("ld_idle_stall", ens(), 32'b000000);
    tick();
    chk("ld_req", {31'd0, dm_req}, 1);
    chk("ld_we", {31'd0, dm_we}, 0);
    chk("ld_addr", dm_addr, 32'h100);
    tick();
    tick();
    dm_ack = 1; dm_rdata = 32'h12345678;
    tick();
    dm_ack = 0; dm_rdata = 0;
    chk("ld_done_req", {31'd0, dm_req}, 0);
    chk("ld_done_enables", ens(), 32'b111110);
    chk("ld_data", M_load_data, 32'h12345678);
    chk("ld_perf_mem", perf_mem_stall, 4);
    M_MemRead = 0;
    tick();
    chk("ld_idle_perf", perf_mem_stall, 4);

    // 2. Store with immediate ack.
    M_MemWrite = 1; M_ALU_result = 32'h40; M_Rt_data = 32'hA5A5A5A5;
    #1 chk("st_idle_stall", ens(), 32'b000000);
    tick();
    M_ALU_result = 0; M_Rt_data = 0;
    chk("st_req", {31'd0, dm_req}, 1);
    chk("st_we", {31'd0, dm_we}, 1);
    chk("st_addr", dm_addr, 32'h40);
    chk("st_wdata", dm_wdata, 32'hA5A5A5A5);
    dm_ack = 1;
    tick();
    dm_ack = 0; M_MemWrite = 0;
    chk("st_done_req", {31'd0, dm_req}, 0);
    chk("st_perf_mem", perf_mem_stall, 6);
    chk("st_bus_err", {31'd0, bus_err}, 0);
    chk("st_load_kept", M_load_data, 32'h12345678);
    tick();

    // 3. Timeout: 16 REQ cycles without ack.
    M_MemRead = 1; M_ALU_result = 32'h80;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_req_cycle16", {31'd0, dm_req}, 1);
    chk("to_no_err_yet", {31'd0, bus_err}, 0);
    tick();
    chk("to_done_req", {31'd0, dm_req}, 0);
    chk("to_bus_err", {31'd0, bus_err}, 1);
    chk("to_load_zero", M_load_data, 0);
    chk("to_perf_mem", perf_mem_stall, 23);
    M_MemRead = 0;
    dm_ack = 1; dm_rdata = 32'hDEADBEEF;  // stray ack outside REQ
    tick();
    tick();
    dm_ack = 0; dm_rdata = 0;
    chk("to_err_sticky", {31'd0, bus_err}, 1);
    chk("stray_ack_req", {31'd0, dm_req}, 0);
    chk("stray_ack_load", M_load_data, 0);

    // 4. Load-use bubble, then same with $0.
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_WR_out = 5'd5; ID_Rs = 5'd5; ID_Rt = 5'd9;
    #1 chk("lu_enables", ens(), 32'b001111);
    tick();
    clr_in();
    chk("lu_perf", perf_lu_stall, 1);
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_WR_out = 5'd0; ID_Rs = 5'd0;
    #1 chk("lu_r0_enables", ens(), 32'b111110);
    tick();
    clr_in();
    chk("lu_r0_perf", perf_lu_stall, 1);

    // 5. Load-use coincident with a memory access.
    M_MemRead = 1; M_ALU_result = 32'h200;
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_WR_out = 5'd8; ID_Rt = 5'd8;
    #1 chk("co_idle_enables", ens(), 32'b000000);
    tick();
    chk("co_req_enables", ens(), 32'b000000);
    dm_ack = 1; dm_rdata = 32'h0BADF00D;
    tick();
    dm_ack = 0;
    chk("co_done_bubble", ens(), 32'b001111);
    tick();
    clr_in();
    chk("co_perf_lu", perf_lu_stall, 2);
    chk("co_perf_mem", perf_mem_stall, 25);
    chk("co_load", M_load_data, 32'h0BADF00D);

    // 6. Reset mid-REQ, then back-to-back loads.
    M_MemRead = 1; M_ALU_result = 32'h300;
    tick();
    chk("mr_req", {31'd0, dm_req}, 1);
    rst = 1;
    #1;
    chk("mr_req_drop", {31'd0, dm_req}, 0);
    chk("mr_perf_mem", perf_mem_stall, 0);
    chk("mr_perf_lu", perf_lu_stall, 0);
    chk("mr_bus_err", {31'd0, bus_err}, 0);
    chk("mr_enables", ens(), 32'b111110);
    tick();
    rst = 0;
    M_ALU_result = 32'h400;
    #1 chk("b2b_a_stall", ens(), 32'b000000);
    tick();
    chk("b2b_a_addr", dm_addr, 32'h400);
    dm_ack = 1; dm_rdata = 32'h11111111;
    tick();
    dm_ack = 0;
    chk("b2b_a_data", M_load_data, 32'h11111111);
    chk("b2b_a_done_req", {31'd0, dm_req}, 0);
    tick();
    M_ALU_result = 32'h404;
    chk("b2b_b_idle_req", {31'd0, dm_req}, 0);
    chk("b2b_b_stall", ens(), 32'b000000);
    tick();
    chk("b2b_b_req", {31'd0, dm_req}, 1);
    chk("b2b_b_addr", dm_addr, 32'h404);
    dm_ack = 1; dm_rdata = 32'h22222222;
    tick();
    dm_ack = 0;
    M_MemRead = 0;
    chk("b2b_b_data", M_load_data, 32'h22222222);
    chk("b2b_perf_mem", perf_mem_stall, 4);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
